// File: rtl/jk_seq_driver.sv
// jk_seq_driver: shadow modulo-MOD counter that produces per-bit J/K drive for
// an external bank of JK flip-flops. It also checks the bank's q outputs against
// the shadow copy and holds a sticky mismatch flag.
module jk_seq_driver #(
   parameter int WIDTH      = 4,
   parameter int MOD        = 10,
   parameter bit USE_TOGGLE = 1'b0
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [1:0]       cmd,
   input  logic [WIDTH-1:0] load_val,
   input  logic             chk_en,
   input  logic             err_clr,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             bank_clr,
   output logic [WIDTH-1:0] cur,
   output logic             tc,
   output logic             load_err,
   output logic             err
);

   localparam logic [WIDTH-1:0] LAST    = WIDTH'(MOD - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

   localparam logic [1:0] CMD_HOLD = 2'b00;
   localparam logic [1:0] CMD_UP   = 2'b01;
   localparam logic [1:0] CMD_DOWN = 2'b10;
   localparam logic [1:0] CMD_LOAD = 2'b11;

   // Increment with wrap at MOD rather than at 2^WIDTH.
   function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
      return (v == LAST) ? '0 : v + 1'b1;
   endfunction

   // Decrement with wrap from 0 to MOD-1.
   function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
      return (v == '0) ? LAST : v - 1'b1;
   endfunction

   // A load value is legal only inside the modulo range.
   function automatic logic load_ok(input logic [WIDTH-1:0] v);
      return ({1'b0, v} < MOD_EXT);
   endfunction

   logic [WIDTH-1:0] cur_r;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] chg;
   logic             bank_clr_r;
   logic             load_err_r;
   logic             err_r;
   logic             active;
   logic             illegal_load;
   logic             tc_c;

   // Next-state, terminal count and illegal-load detect; commands are ignored
   // while the bank is being cleared or reset is asserted.
   always_comb begin
      active       = clr_n & ~bank_clr_r;
      nxt          = cur_r;
      illegal_load = 1'b0;
      tc_c         = 1'b0;
      if (active) begin
         case (cmd)
            CMD_HOLD: nxt = cur_r;
            CMD_UP: begin
               nxt  = step_up(cur_r);
               tc_c = (cur_r == LAST);
            end
            CMD_DOWN: begin
               nxt  = step_down(cur_r);
               tc_c = (cur_r == '0);
            end
            CMD_LOAD: begin
               if (load_ok(load_val)) begin
                  nxt = load_val;
               end else begin
                  nxt          = cur_r;
                  illegal_load = 1'b1;
               end
            end
            default: nxt = cur_r;
         endcase
      end
   end

   // Per-bit excitation: unchanged bits get memory (0/0), changing bits get
   // either set/reset or toggle encoding, all forced to 0/0 when inactive.
   always_comb begin
      chg = (cur_r ^ nxt) & {WIDTH{active}};
      j   = '0;
      k   = '0;
      if (USE_TOGGLE) begin
         j = chg;
         k = chg;
      end else begin
         j = chg & nxt;
         k = chg & ~nxt;
      end
   end

   // Shadow state, bank clear sequencing, load error pulse and sticky compare.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         cur_r      <= '0;
         bank_clr_r <= 1'b1;
         load_err_r <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         cur_r      <= nxt;
         bank_clr_r <= 1'b0;
         load_err_r <= illegal_load;
         if (chk_en && !bank_clr_r && (q_fb != cur_r)) begin
            err_r <= 1'b1;
         end else if (err_clr) begin
            err_r <= 1'b0;
         end
      end
   end

   assign cur      = cur_r;
   assign bank_clr = bank_clr_r;
   assign tc       = tc_c;
   assign load_err = load_err_r;
   assign err      = err_r;

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver: two instances (set/reset and toggle encoding), each
// driving its own behavioural JK bank that feeds q back to the driver.
module tb_jk_seq_driver;

   logic       clk;
   logic       clr_n;
   logic [1:0] cmd;
   logic [3:0] load_val;
   logic       chk_en;
   logic       err_clr;
   logic       fault;

   logic [3:0] q0, q1, q_fb0, q_fb1;
   logic [3:0] j0, k0, cur0, j1, k1, cur1;
   logic       bank_clr0, tc0, load_err0, err0;
   logic       bank_clr1, tc1, load_err1, err1;

   int checks;
   int errors;

   jk_seq_driver #(.WIDTH(4), .MOD(10), .USE_TOGGLE(1'b0)) dut0 (
      .clk(clk), .clr_n(clr_n), .cmd(cmd), .load_val(load_val),
      .chk_en(chk_en), .err_clr(err_clr), .q_fb(q_fb0),
      .j(j0), .k(k0), .bank_clr(bank_clr0), .cur(cur0),
      .tc(tc0), .load_err(load_err0), .err(err0)
   );

   jk_seq_driver #(.WIDTH(4), .MOD(10), .USE_TOGGLE(1'b1)) dut1 (
      .clk(clk), .clr_n(clr_n), .cmd(cmd), .load_val(load_val),
      .chk_en(chk_en), .err_clr(err_clr), .q_fb(q_fb1),
      .j(j1), .k(k1), .bank_clr(bank_clr1), .cur(cur1),
      .tc(tc1), .load_err(load_err1), .err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural JK bank for instance 0.
   always_ff @(posedge clk) begin
      if (bank_clr0) begin
         q0 <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            case ({j0[i], k0[i]})
               2'b10: q0[i] <= 1'b1;
               2'b01: q0[i] <= 1'b0;
               2'b11: q0[i] <= ~q0[i];
               default: ;
            endcase
         end
      end
   end

   // Behavioural JK bank for instance 1.
   always_ff @(posedge clk) begin
      if (bank_clr1) begin
         q1 <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            case ({j1[i], k1[i]})
               2'b10: q1[i] <= 1'b1;
               2'b01: q1[i] <= 1'b0;
               2'b11: q1[i] <= ~q1[i];
               default: ;
            endcase
         end
      end
   end

   // Fault injection: bit 2 of bank 0's output stuck at 0.
   assign q_fb0 = fault ? (q0 & 4'b1011) : q0;
   assign q_fb1 = q1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr_n    = 1'b0;
      cmd      = 2'b01;
      load_val = 4'd0;
      chk_en   = 1'b0;
      err_clr  = 1'b0;
      fault    = 1'b0;
      tick();
      tick();
      checks++; if (cur0 !== 4'd0) begin errors++; $display("FAIL reset_cur: got %0d want 0", cur0); end
      checks++; if (bank_clr0 !== 1'b1) begin errors++; $display("FAIL reset_bank_clr: got %b want 1", bank_clr0); end
      checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err0); end
      checks++; if (load_err0 !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b want 0", load_err0); end
      checks++; if ({j0, k0} !== 8'h00) begin errors++; $display("FAIL reset_jk: got j=%b k=%b want 0", j0, k0); end
      // Release: bank_clr still 1 for this cycle, down-from-0 must be ignored.
      clr_n = 1'b1;
      cmd   = 2'b10;
      #1;
      checks++; if ({j0, k0, j1, k1} !== 16'h0000) begin errors++; $display("FAIL release_jk: got j0=%b k0=%b j1=%b k1=%b want 0", j0, k0, j1, k1); end
      checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL release_tc: got %b want 0", tc0); end
      tick();
      checks++; if (bank_clr0 !== 1'b0) begin errors++; $display("FAIL release_bank_clr: got %b want 0", bank_clr0); end
      checks++; if (cur0 !== 4'd0) begin errors++; $display("FAIL release_cmd_ignored: got %0d want 0", cur0); end
   endtask

   task automatic test_up_count();
      logic [3:0] e;
      e   = 4'd0;
      cmd = 2'b01;
      #1;
      for (int i = 0; i < 12; i++) begin
         checks++; if (tc0 !== (e == 4'd9)) begin errors++; $display("FAIL up_tc: got %b want %b at cur=%0d", tc0, (e == 4'd9), e); end
         if (e == 4'd9) begin
            checks++; if (j0 !== 4'b0000) begin errors++; $display("FAIL up_wrap_j: got %b want 0000", j0); end
            checks++; if (k0 !== 4'b1001) begin errors++; $display("FAIL up_wrap_k: got %b want 1001", k0); end
            checks++; if ({j1, k1} !== 8'b1001_1001) begin errors++; $display("FAIL up_wrap_toggle: got j=%b k=%b want 1001/1001", j1, k1); end
         end
         tick();
         e = (e == 4'd9) ? 4'd0 : e + 4'd1;
         checks++; if (cur0 !== e) begin errors++; $display("FAIL up_cur: got %0d want %0d", cur0, e); end
         checks++; if (q_fb0 !== e) begin errors++; $display("FAIL up_bank0: got %0d want %0d", q_fb0, e); end
         checks++; if (q_fb1 !== e) begin errors++; $display("FAIL up_bank1: got %0d want %0d", q_fb1, e); end
      end
   endtask

   task automatic test_down_wrap();
      cmd      = 2'b11;
      load_val = 4'd0;
      tick();
      checks++; if (cur1 !== 4'd0) begin errors++; $display("FAIL down_preload: got %0d want 0", cur1); end
      cmd = 2'b10;
      #1;
      checks++; if (j1 !== 4'b1001 || k1 !== 4'b1001) begin errors++; $display("FAIL down_toggle_jk: got j=%b k=%b want 1001/1001", j1, k1); end
      checks++; if (j0 !== 4'b1001 || k0 !== 4'b0000) begin errors++; $display("FAIL down_setreset_jk: got j=%b k=%b want 1001/0000", j0, k0); end
      checks++; if (tc1 !== 1'b1) begin errors++; $display("FAIL down_tc: got %b want 1", tc1); end
      tick();
      checks++; if (cur1 !== 4'd9) begin errors++; $display("FAIL down_cur1: got %0d want 9", cur1); end
      checks++; if (q_fb1 !== 4'd9) begin errors++; $display("FAIL down_bank1: got %0d want 9", q_fb1); end
      checks++; if (cur0 !== 4'd9) begin errors++; $display("FAIL down_cur0: got %0d want 9", cur0); end
      checks++; if (tc1 !== 1'b0) begin errors++; $display("FAIL down_tc_after: got %b want 0", tc1); end
   endtask

   task automatic test_loads();
      cmd      = 2'b11;
      load_val = 4'd7;
      tick();
      checks++; if (cur0 !== 4'd7) begin errors++; $display("FAIL load7_cur: got %0d want 7", cur0); end
      checks++; if (load_err0 !== 1'b0) begin errors++; $display("FAIL load7_err: got %b want 0", load_err0); end
      load_val = 4'd12;
      #1;
      checks++; if ({j0, k0} !== 8'h00) begin errors++; $display("FAIL load12_jk: got j=%b k=%b want 0", j0, k0); end
      tick();
      checks++; if (cur0 !== 4'd7) begin errors++; $display("FAIL load12_cur: got %0d want 7", cur0); end
      checks++; if (load_err0 !== 1'b1) begin errors++; $display("FAIL load12_pulse: got %b want 1", load_err0); end
      cmd = 2'b00;
      tick();
      checks++; if (load_err0 !== 1'b0) begin errors++; $display("FAIL load12_pulse_end: got %b want 0", load_err0); end
      checks++; if (cur0 !== 4'd7) begin errors++; $display("FAIL hold_cur: got %0d want 7", cur0); end
      load_val = 4'd9;
      cmd      = 2'b11;
      tick();
      checks++; if (cur0 !== 4'd9 || load_err0 !== 1'b0) begin errors++; $display("FAIL load9: got cur=%0d le=%b want 9/0", cur0, load_err0); end
   endtask

   task automatic test_mismatch();
      cmd      = 2'b11;
      load_val = 4'd3;
      tick();
      chk_en = 1'b1;
      fault  = 1'b1;
      cmd    = 2'b01;
      tick();
      checks++; if (cur0 !== 4'd4 || err0 !== 1'b0) begin errors++; $display("FAIL mm_before: got cur=%0d err=%b want 4/0", cur0, err0); end
      tick();
      checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL mm_detect: got %b want 1", err0); end
      checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL mm_clean_inst: got %b want 0", err1); end
      cmd = 2'b00;
      tick();
      checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL mm_sticky: got %b want 1", err0); end
      // Clear while the fault is still present: mismatch wins.
      err_clr = 1'b1;
      tick();
      checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL mm_clr_vs_new: got %b want 1", err0); end
      fault = 1'b0;
      tick();
      checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL mm_clear: got %b want 0", err0); end
      err_clr = 1'b0;
      chk_en  = 1'b0;
   endtask

   task automatic test_reset_mid();
      cmd      = 2'b11;
      load_val = 4'd6;
      tick();
      checks++; if (cur0 !== 4'd6) begin errors++; $display("FAIL mid_load6: got %0d want 6", cur0); end
      cmd   = 2'b01;
      clr_n = 1'b0;
      #1;
      checks++; if ({j0, k0, j1, k1} !== 16'h0000) begin errors++; $display("FAIL mid_jk_in_reset: got j0=%b k0=%b want 0", j0, k0); end
      tick();
      checks++; if (cur0 !== 4'd0) begin errors++; $display("FAIL mid_cur: got %0d want 0", cur0); end
      checks++; if (bank_clr0 !== 1'b1) begin errors++; $display("FAIL mid_bank_clr: got %b want 1", bank_clr0); end
      checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL mid_tc: got %b want 0", tc0); end
      cmd      = 2'b11;
      load_val = 4'd15;
      tick();
      checks++; if (load_err0 !== 1'b0) begin errors++; $display("FAIL mid_load_err: got %b want 0", load_err0); end
      clr_n = 1'b1;
      cmd   = 2'b01;
      tick();
      checks++; if (cur0 !== 4'd0 || bank_clr0 !== 1'b0) begin errors++; $display("FAIL mid_release: got cur=%0d bc=%b want 0/0", cur0, bank_clr0); end
      tick();
      checks++; if (cur0 !== 4'd1 || q_fb0 !== 4'd1) begin errors++; $display("FAIL mid_resume: got cur=%0d q=%0d want 1/1", cur0, q_fb0); end
      tick();
      checks++; if (cur1 !== 4'd2 || q_fb1 !== 4'd2) begin errors++; $display("FAIL mid_resume_toggle: got cur=%0d q=%0d want 2/2", cur1, q_fb1); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_up_count();
      test_down_wrap();
      test_loads();
      test_mismatch();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
